// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and owner encodings for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts WAIT cycles from zero and flags the last allowed one
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [W-1:0] count;
  assign o_expired = count == W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) count <= '0;
    else count <= i_clear ? '0 : (i_enable && !o_expired) ? count + 1'b1 : count;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-outstanding fetch/data arbiter onto one memory port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_if_req,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  output logic                    o_if_rvalid,
  input  logic                    i_dm_req,
  input  logic                    i_dm_we,
  input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
  input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_dm_wstrb,
  output logic [DATA_WIDTH-1:0]   o_dm_rdata,
  output logic                    o_dm_done,
  output logic                    o_if_stall,
  output logic                    o_dm_stall,
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_timeout_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t state, state_n;
  owner_t owner;
  logic [SW-1:0] starve;
  logic fetch_first, gnt_if, gnt_dm, expired, wait_done;
  assign fetch_first = starve == SW'(STARVE_LIMIT);
  assign gnt_if = i_if_req & (~i_dm_req | fetch_first);
  assign gnt_dm = i_dm_req & ~gnt_if;
  assign wait_done = i_mem_rvalid | expired;
  assign o_mem_valid = state == ISSUE;
  assign o_if_rvalid = state == RESP && owner == OWN_IF;
  assign o_dm_done = state == RESP && owner == OWN_DM;
  assign o_if_stall = i_if_req & ~o_if_rvalid;
  assign o_dm_stall = i_dm_req & ~o_dm_done;
  mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (state != WAIT),
    .i_enable (state == WAIT),
    .o_expired(expired)
  );
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (gnt_if | gnt_dm) ? ISSUE : IDLE;
      ISSUE:   state_n = i_mem_ready ? WAIT : ISSUE;
      WAIT:    state_n = wait_done ? RESP : WAIT;
      default: state_n = IDLE;
    endcase
  end
  // a timed-out transaction still completes, returning zero data
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      owner <= OWN_IF;
      starve <= '0;
      o_mem_we <= 1'b0;
      o_mem_addr <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
      o_if_rdata <= '0;
      o_dm_rdata <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      if (state == IDLE && (gnt_if || gnt_dm)) begin
        owner <= gnt_dm ? OWN_DM : OWN_IF;
        starve <= gnt_if ? '0 : (i_if_req && !fetch_first) ? starve + 1'b1 : starve;
        o_mem_we <= gnt_dm & i_dm_we;
        o_mem_addr <= gnt_dm ? i_dm_addr : i_if_addr;
        o_mem_wdata <= gnt_dm ? i_dm_wdata : '0;
        o_mem_wstrb <= gnt_dm ? i_dm_wstrb : '0;
      end
      if (state == WAIT && wait_done) begin
        if (owner == OWN_DM) o_dm_rdata <= i_mem_rvalid ? i_mem_rdata : '0;
        else o_if_rdata <= i_mem_rvalid ? i_mem_rdata : '0;
        o_timeout_err <= o_timeout_err | ~i_mem_rvalid;
      end
    end
endmodule
